// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Merges ALU and load results into a single register-file write port.
//   Accepted requests are queued in a DEPTH-entry FIFO. The FIFO head is
//   written to the register file on every clock edge where the FIFO holds
//   an entry. When both sources are valid in the same cycle, the load wins.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   alu_valid/ready/rd/data   ALU result handshake
//   ld_valid/ready/rd/data    load result handshake (priority source)
//   rf_wen/rf_rd/rf_wdata     registered register-file write port
//   pending               per-register "write in flight" scoreboard bits
//   count                 FIFO occupancy, 0..DEPTH
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic [31:0] pending,
  output logic [4:0]  count
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [4:0]    r_mem_rd   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [4:0]    r_count;
  logic          r_rf_wen;
  logic [4:0]    r_rf_rd;
  logic [31:0]   r_rf_wdata;

  logic          w_space;
  logic          w_ld_acc;
  logic          w_alu_acc;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_wr_rd;
  logic [31:0]   w_wr_data;
  logic [31:0]   w_pend;

  // Ready looks only at the current occupancy, so a full FIFO refuses
  // new requests even in a cycle where it is also draining an entry.
  assign w_space   = (r_count < DEPTH_C);
  assign ld_ready  = !reset && w_space;
  assign alu_ready = !reset && w_space && !ld_valid;

  assign w_ld_acc  = ld_valid && ld_ready;
  assign w_alu_acc = alu_valid && alu_ready;

  assign w_wr_rd   = w_ld_acc ? ld_rd   : alu_rd;
  assign w_wr_data = w_ld_acc ? ld_data : alu_data;

  // Writes to x0 are handshaken but dropped here, never enqueued.
  assign w_push = (w_ld_acc || w_alu_acc) && (w_wr_rd != 5'd0);
  assign w_pop  = (r_count != 5'd0);

  // Storage needs no reset: only entries covered by r_count are ever read.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem_rd[r_wptr]   <= w_wr_rd;
      r_mem_data[r_wptr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= 5'd0;
      r_rf_wen   <= 1'b0;
      r_rf_rd    <= 5'd0;
      r_rf_wdata <= 32'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      r_rf_wen <= w_pop;
      if (w_pop) begin
        r_rf_rd    <= r_mem_rd[r_rptr];
        r_rf_wdata <= r_mem_data[r_rptr];
        r_rptr     <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk the live FIFO window starting at the read pointer; the index
  // wraps naturally because DEPTH is a power of two.
  always_comb begin
    w_pend = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(r_count)) begin
        w_pend[r_mem_rd[r_rptr + PW'(k)]] = 1'b1;
      end
    end
    if (r_rf_wen) begin
      w_pend[r_rf_rd] = 1'b1;
    end
    w_pend[0] = 1'b0;
  end

  assign pending  = w_pend;
  assign count    = r_count;
  assign rf_wen   = r_rf_wen;
  assign rf_rd    = r_rf_rd;
  assign rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//   Directed stimulus with a scoreboard queue: every accepted non-x0 request
//   is pushed with its expected rd/data; a negedge monitor pops and compares
//   each register-file write and checks rf_wen timing and the pending vector.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pending;
  logic [4:0]  count;

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .rf_wen    (rf_wen),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .pending   (pending),
    .count     (count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [36:0] sb[$];
  int          m_count = 0;
  bit          m_wen_exp = 1'b0;
  bit          mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: rf_* and pending are sampled at the falling edge.
  always @(negedge clk) begin
    logic [31:0] ep;
    logic [36:0] e;
    if (mon_en) begin
      chk("rf_wen", {31'd0, rf_wen}, {31'd0, m_wen_exp});
      ep = 32'd0;
      if (m_wen_exp && sb.size() != 0) begin
        e = sb.pop_front();
        chk("rf_rd", {27'd0, rf_rd}, {27'd0, e[36:32]});
        chk("rf_wdata", rf_wdata, e[31:0]);
        ep[e[36:32]] = 1'b1;
      end
      foreach (sb[i]) ep[sb[i][36:32]] = 1'b1;
      ep[0] = 1'b0;
      chk("pending", pending, ep);
    end
  end

  // One clock cycle of stimulus: drive after the falling edge, check
  // handshake/occupancy, then advance the reference model after the edge.
  task automatic step(input logic rst,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic av, input logic [4:0] ard, input logic [31:0] adat);
    logic exp_lr, exp_ar;
    bit   push;
    @(negedge clk);
    #1;
    reset = rst; ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    #1;
    exp_lr = !rst && (m_count < DEPTH);
    exp_ar = exp_lr && !lv;
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, exp_lr});
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, exp_ar});
    chk("count", {27'd0, count}, 32'(m_count));
    @(posedge clk);
    #1;
    m_wen_exp = !rst && (m_count > 0);
    if (rst) begin
      sb.delete();
      m_count = 0;
    end else begin
      push = 1'b0;
      if (lv && exp_lr) begin
        if (lrd != 5'd0) begin sb.push_back({lrd, ldat}); push = 1'b1; end
      end else if (av && exp_ar) begin
        if (ard != 5'd0) begin sb.push_back({ard, adat}); push = 1'b1; end
      end
      if (push && m_count == 0) m_count = 1;
      else if (!push && m_count > 0) m_count = m_count - 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; ld_valid = 1'b0; alu_valid = 1'b0;
    ld_rd = 5'd0; alu_rd = 5'd0; ld_data = 32'd0; alu_data = 32'd0;
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    mon_en = 1'b1;

    // Single ALU write, accepted in the first cycle out of reset.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345678);
    idle(3);

    // Contention: load wins, ALU held and taken one cycle later.
    step(1'b0, 1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd4, 32'h0000BBBB);
    step(1'b0, 1'b0, 5'd0, 32'd0,        1'b1, 5'd4, 32'h0000BBBB);
    idle(3);

    // Burst of four back-to-back writes, mixed sources.
    step(1'b0, 1'b1, 5'd11, 32'h0000_1111, 1'b0, 5'd0,  32'd0);
    step(1'b0, 1'b0, 5'd0,  32'd0,         1'b1, 5'd12, 32'h0000_2222);
    step(1'b0, 1'b1, 5'd13, 32'h0000_3333, 1'b1, 5'd14, 32'hDEAD_0000);
    step(1'b0, 1'b0, 5'd0,  32'd0,         1'b1, 5'd14, 32'h0000_4444);
    idle(3);

    // Write to x0 is consumed and discarded.
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555AAAA);
    idle(2);

    // Repeated writes to the same register stay ordered; pending holds.
    step(1'b0, 1'b1, 5'd7, 32'h0000_0071, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0,         1'b1, 5'd7, 32'h0000_0072);
    step(1'b0, 1'b1, 5'd7, 32'h0000_0073, 1'b0, 5'd0, 32'd0);
    idle(3);

    // Reset mid-stream with a write queued and another offered.
    step(1'b0, 1'b1, 5'd20, 32'hBAD0_0020, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b0, 5'd0,  32'd0,         1'b1, 5'd21, 32'hBAD0_0021);
    step(1'b1, 1'b1, 5'd22, 32'hBAD0_0022, 1'b1, 5'd23, 32'hBAD0_0023);
    chk("count_after_reset", {27'd0, count}, 32'd0);
    chk("pending_after_reset", pending, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0909);
    idle(2);

    // Stream rd=1..10 at one per cycle across pointer wrap.
    for (int r = 1; r <= 10; r++) begin
      if (r % 2 == 0)
        step(1'b0, 1'b1, 5'(r), 32'hC0DE_0000 + 32'(r), 1'b0, 5'd0, 32'd0);
      else
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 32'hC0DE_0000 + 32'(r));
    end
    idle(4);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
